// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions,
// exception codes and the fixed pipeline addresses.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;

    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
    localparam logic [31:0] RESET_PC     = 32'h0000_3000;

endpackage

// File: rtl/cp0.sv
// Coprocessor 0 in the M stage: SR/Cause/EPC/PRId register file, interrupt
// versus exception arbitration producing Req, and the eret return address.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_2024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] Din,
    input  logic        en,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] Dout,
    output logic [31:0] EPCOut,
    output logic        Req
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        wr_sr;
    logic        wr_epc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // Interrupts use the live HWInt lines; the sampled IP is only for software.
    always_comb begin
        int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
        exc_req = (ExcCodeIn != EXC_INT) & ~sr_exl;
        Req     = int_req | exc_req;
        wr_sr   = en & ~Req & (A2 == REG_SR);
        wr_epc  = en & ~Req & (A2 == REG_EPC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= HWInt;
            if (Req) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? EXC_INT : ExcCodeIn;
                cause_bd  <= BDIn;
                epc       <= BDIn ? (VPC - 32'd4) : VPC;
            end else begin
                if (wr_sr) begin
                    sr_im  <= Din[SR_IM_HI:SR_IM_LO];
                    sr_ie  <= Din[SR_IE];
                    sr_exl <= EXLClr ? 1'b0 : Din[SR_EXL];
                end else if (EXLClr) begin
                    sr_exl <= 1'b0;
                end
                if (wr_epc) begin
                    epc <= Din;
                end
            end
        end
    end

    always_comb begin
        sr_word                            = '0;
        sr_word[SR_IM_HI:SR_IM_LO]         = sr_im;
        sr_word[SR_EXL]                    = sr_exl;
        sr_word[SR_IE]                     = sr_ie;
        cause_word                         = '0;
        cause_word[CAUSE_BD]               = cause_bd;
        cause_word[CAUSE_IP_HI:CAUSE_IP_LO] = cause_ip;
        cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
    end

    // No write-to-read bypass on Dout; only EPCOut forwards an in-flight mtc0.
    always_comb begin
        case (A1)
            REG_SR:    Dout = sr_word;
            REG_CAUSE: Dout = cause_word;
            REG_EPC:   Dout = epc;
            REG_PRID:  Dout = PRID_VALUE;
            default:   Dout = '0;
        endcase
        EPCOut = (en && (A2 == REG_EPC)) ? Din : epc;
    end

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: stimulus pushes expected outputs into a queue and a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_cp0;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] Din;
    logic        en;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] Dout;
    logic [31:0] EPCOut;
    logic        Req;

    cp0 #(.PRID_VALUE(32'h0000_2024)) dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .Din(Din), .en(en),
        .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .Dout(Dout), .EPCOut(EPCOut), .Req(Req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 Req, 1 Dout, 2 EPCOut
        logic [31:0] value;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                0:       act = {31'b0, Req};
                1:       act = Dout;
                default: act = EPCOut;
            endcase
            n_cmp++;
            if (act !== e.value) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.value);
            end
        end
    end

    task automatic expect_out(input int kind, input logic [31:0] value, input string name);
        exp_t e;
        e.kind  = kind;
        e.value = value;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        en        = 1'b0;
        A1        = 5'd0;
        A2        = 5'd0;
        Din       = 32'h0;
        VPC       = 32'h0;
        BDIn      = 1'b0;
        ExcCodeIn = 5'd0;
        HWInt     = 6'd0;
        EXLClr    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; A1 = 5'd0; A2 = 5'd0; Din = 32'h0; VPC = 32'h0;
        BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        next_cycle(); A1 = 5'd12;
        expect_out(1, 32'h0, "rst_sr"); expect_out(0, 32'h0, "rst_req"); expect_out(2, 32'h0, "rst_epcout");
        next_cycle(); A1 = 5'd13; en = 1'b1; A2 = 5'd3; Din = 32'h1234_5678;
        expect_out(1, 32'h0, "rst_cause");
        next_cycle(); A1 = 5'd3;
        expect_out(1, 32'h0, "unimpl_reg_read");

        // mtc0 SR all ones: only implemented fields stick, no read bypass
        next_cycle(); en = 1'b1; A2 = 5'd12; Din = 32'hFFFF_FFFF; A1 = 5'd12;
        expect_out(1, 32'h0, "sr_no_bypass");
        next_cycle(); A1 = 5'd12;
        expect_out(1, 32'h0000_FC03, "sr_after_mtc0");
        next_cycle(); A1 = 5'd13;
        expect_out(1, 32'h0, "cause_unchanged");
        next_cycle(); en = 1'b1; A2 = 5'd12; Din = 32'h0;

        // Overflow exception
        next_cycle(); ExcCodeIn = 5'd12; VPC = 32'h0000_3010; A1 = 5'd15;
        expect_out(0, 32'h1, "ov_req"); expect_out(1, 32'h0000_2024, "prid");
        next_cycle(); ExcCodeIn = 5'd12; VPC = 32'h0000_3010; A1 = 5'd14;
        expect_out(0, 32'h0, "ov_masked_by_exl"); expect_out(1, 32'h0000_3010, "ov_epc");
        expect_out(2, 32'h0000_3010, "ov_epcout");
        next_cycle(); A1 = 5'd13;
        expect_out(1, 32'h0000_0030, "ov_cause");
        next_cycle(); A1 = 5'd12;
        expect_out(1, 32'h0000_0002, "ov_sr_exl");

        // eret, then delay-slot AdEL
        next_cycle(); EXLClr = 1'b1;
        expect_out(0, 32'h0, "eret_req");
        next_cycle(); BDIn = 1'b1; VPC = 32'h0000_3024; ExcCodeIn = 5'd4; A1 = 5'd12;
        expect_out(0, 32'h1, "bd_req"); expect_out(1, 32'h0, "eret_cleared_exl");
        next_cycle(); A1 = 5'd14;
        expect_out(1, 32'h0000_3020, "bd_epc");
        next_cycle(); A1 = 5'd13;
        expect_out(1, 32'h8000_0010, "bd_cause");

        // mtc0 SR=0x401 while EXL=1 (clears EXL via Din), then interrupt vs RI
        next_cycle(); en = 1'b1; A2 = 5'd12; Din = 32'h0000_0401;
        expect_out(0, 32'h0, "mtc0_sr_req");
        next_cycle(); HWInt = 6'b000001; ExcCodeIn = 5'd10; VPC = 32'h0000_3040; A1 = 5'd12;
        expect_out(0, 32'h1, "int_req"); expect_out(1, 32'h0000_0401, "int_sr");
        next_cycle(); A1 = 5'd13;
        expect_out(1, 32'h0000_0400, "int_cause"); expect_out(0, 32'h0, "int_masked");
        next_cycle(); A1 = 5'd13;
        expect_out(1, 32'h0000_0000, "ip_lag_clear");
        next_cycle(); A1 = 5'd14;
        expect_out(1, 32'h0000_3040, "int_epc");

        // Req suppresses mtc0 EPC
        next_cycle(); EXLClr = 1'b1;
        next_cycle(); ExcCodeIn = 5'd5; VPC = 32'h0000_3050; en = 1'b1; A2 = 5'd14; Din = 32'hDEAD_BEEC;
        expect_out(0, 32'h1, "supp_req"); expect_out(2, 32'hDEAD_BEEC, "supp_epcout_fwd");
        next_cycle(); A1 = 5'd14;
        expect_out(1, 32'h0000_3050, "supp_epc");

        // eret with forwarded EPC
        next_cycle(); en = 1'b1; A2 = 5'd14; Din = 32'h0000_3100; EXLClr = 1'b1; A1 = 5'd14;
        expect_out(2, 32'h0000_3100, "eret_fwd"); expect_out(1, 32'h0000_3050, "eret_epc_old");
        expect_out(0, 32'h0, "eret_fwd_req");
        next_cycle(); A1 = 5'd14;
        expect_out(1, 32'h0000_3100, "eret_epc_new"); expect_out(2, 32'h0000_3100, "eret_epcout");
        next_cycle(); A1 = 5'd12;
        expect_out(1, 32'h0000_0401, "eret_sr");

        // Held interrupt re-fires once EXL drops
        next_cycle(); HWInt = 6'b000001; VPC = 32'h0000_3060;
        expect_out(0, 32'h1, "hold_int_req");
        next_cycle(); HWInt = 6'b000001; A1 = 5'd13;
        expect_out(0, 32'h0, "hold_masked"); expect_out(1, 32'h0000_0400, "hold_cause");
        next_cycle(); HWInt = 6'b000001; EXLClr = 1'b1;
        expect_out(0, 32'h0, "hold_eret_cycle");
        next_cycle(); HWInt = 6'b000001;
        expect_out(0, 32'h1, "hold_refire");

        // Reset beats a simultaneous Req
        next_cycle(); EXLClr = 1'b1;
        next_cycle(); ExcCodeIn = 5'd8; VPC = 32'h0000_3070; reset = 1'b1;
        expect_out(0, 32'h1, "rst_req_comb");
        next_cycle(); A1 = 5'd12;
        expect_out(1, 32'h0, "rst_win_sr");
        next_cycle(); A1 = 5'd14;
        expect_out(1, 32'h0, "rst_win_epc");
        next_cycle(); A1 = 5'd13;
        expect_out(1, 32'h0, "rst_win_cause");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
